// File: rtl/bnn_mac_array.sv
// Binary-weight MAC engine: accumulates DEPTH beats of LANES ternary activations
// against NUM_OUT rows of +/-1 weights and hands off sums plus thresholded bits.
module bnn_mac_array #(
  parameter int LANES   = 3,
  parameter int DEPTH   = 36,
  parameter int NUM_OUT = 2,
  parameter int ACC_W   = 8,
  localparam int CH_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int BEAT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [CH_W-1:0]          w_ch,
  input  logic [BEAT_W-1:0]        w_addr,
  input  logic [LANES-1:0]         w_data,
  input  logic                     thr_we,
  input  logic [CH_W-1:0]          thr_ch,
  input  logic [ACC_W-1:0]         thr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*LANES-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_OUT*ACC_W-1:0] out_sum,
  output logic [2*NUM_OUT-1:0]     out_bin,
  output logic                     mac_done
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(DEPTH - 1);
  localparam logic signed [ACC_W-1:0] POS_ONE   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] NEG_ONE   = '1;

  state_t                  state, next_state;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [LANES-1:0]        weights [NUM_OUT][DEPTH];
  logic signed [ACC_W-1:0] acc      [NUM_OUT];
  logic signed [ACC_W-1:0] acc_next [NUM_OUT];
  logic signed [ACC_W-1:0] thr      [NUM_OUT];
  logic                    accept;
  logic                    last_beat;
  logic                    cfg_open;

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  // Configuration is only accepted between vectors, so a dot product never mixes weight sets.
  assign cfg_open  = (state == S_ACC) && (beat_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst && w_we && cfg_open && (32'(w_addr) < DEPTH) && (32'(w_ch) < NUM_OUT))
      weights[w_ch][w_addr] <= w_data;
  end

  always_comb begin : beat_sum
    logic signed [ACC_W-1:0] s;
    s = '0;
    for (int c = 0; c < NUM_OUT; c++) begin
      s = '0;
      for (int i = 0; i < LANES; i++) begin
        if (in_data[2*i +: 2] == 2'b01)
          s = s + (weights[c][beat_cnt][i] ? POS_ONE : NEG_ONE);
        else if (in_data[2*i +: 2] == 2'b11)
          s = s + (weights[c][beat_cnt][i] ? NEG_ONE : POS_ONE);
      end
      acc_next[c] = acc[c] + s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) next_state = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_ACC;
      end
      default: next_state = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      out_sum  <= '0;
      out_bin  <= '0;
      mac_done <= 1'b0;
      for (int c = 0; c < NUM_OUT; c++) begin
        acc[c] <= '0;
        thr[c] <= '0;
      end
    end else begin
      mac_done <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          mac_done <= 1'b1;
          for (int c = 0; c < NUM_OUT; c++) begin
            out_sum[c*ACC_W +: ACC_W] <= acc_next[c];
            out_bin[2*c +: 2]         <= (acc_next[c] >= thr[c]) ? 2'b01 : 2'b11;
            acc[c]                    <= '0;
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          for (int c = 0; c < NUM_OUT; c++)
            acc[c] <= acc_next[c];
        end
      end
      // Same cfg_open gate as the weights: the threshold used at the final beat is the one loaded before beat 0.
      if (thr_we && cfg_open && (32'(thr_ch) < NUM_OUT))
        thr[thr_ch] <= thr_data;
    end
  end

endmodule
